// File: rtl/byte_rd_serializer.sv
// byte_rd_serializer: captures a register value on an accepted start and
// streams it to a byte-wide read port, LSB byte first, one byte per
// valid/ready handshake. byte_idx follows the 2-bit byte-select numbering,
// so the host can rebuild the word byte by byte.

module byte_rd_serializer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [1:0]            byte_idx,
    output logic                  done
);

    localparam int unsigned NUM_BYTES = (DATA_WIDTH + 7) / 8;
    localparam logic [1:0]  LastIdx   = 2'(NUM_BYTES - 1);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [1:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic [31:0] data_ext;
    logic        handshake;

    // Zero-extend the input word; unused upper bytes always read back as 0.
    always_comb begin
        data_ext                 = '0;
        data_ext[DATA_WIDTH-1:0] = data_in;
    end

    assign handshake = byte_valid & byte_ready;

    // State register: FSM state, shadow word, byte index and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: capture in IDLE, advance the byte index on handshakes.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start arriving while busy never reaches here, so the
                // shadow cannot be disturbed mid-transfer.
                if (start) begin
                    shadow_d = data_ext;
                    idx_d    = 2'd0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (handshake) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Outputs: byte lane selected from the shadow, zero whenever idle.
    always_comb begin
        busy       = (state_q == StSend);
        byte_valid = (state_q == StSend);
        byte_idx   = idx_q;
        done       = done_q;
        byte_out   = 8'h00;
        if (state_q == StSend) begin
            unique case (idx_q)
                2'd0: byte_out = shadow_q[7:0];
                2'd1: byte_out = shadow_q[15:8];
                2'd2: byte_out = shadow_q[23:16];
                2'd3: byte_out = shadow_q[31:24];
                default: byte_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_rd_serializer.sv
// Bench for byte_rd_serializer: three instances (widths 32, 12, 1) share the
// same stimulus; each is checked every cycle against a byte-list model.

module tb_byte_rd_serializer;

    logic        clk = 1'b0;
    logic        rst, start, byte_ready;
    logic [31:0] din;

    logic       busy_w  [3];
    logic       valid_w [3];
    logic       done_w  [3];
    logic [7:0] bout_w  [3];
    logic [1:0] idx_w   [3];

    always #5 clk = ~clk;

    byte_rd_serializer #(.DATA_WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .start(start), .data_in(din),
        .busy(busy_w[0]), .byte_out(bout_w[0]), .byte_valid(valid_w[0]),
        .byte_ready(byte_ready), .byte_idx(idx_w[0]), .done(done_w[0])
    );

    byte_rd_serializer #(.DATA_WIDTH(12)) u_w12 (
        .clk(clk), .rst(rst), .start(start), .data_in(din[11:0]),
        .busy(busy_w[1]), .byte_out(bout_w[1]), .byte_valid(valid_w[1]),
        .byte_ready(byte_ready), .byte_idx(idx_w[1]), .done(done_w[1])
    );

    byte_rd_serializer #(.DATA_WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start), .data_in(din[0:0]),
        .busy(busy_w[2]), .byte_out(bout_w[2]), .byte_valid(valid_w[2]),
        .byte_ready(byte_ready), .byte_idx(idx_w[2]), .done(done_w[2])
    );

    // Reference model: list of bytes still to deliver and position within it.
    int unsigned wid [3] = '{32, 12, 1};
    int          nb  [3] = '{0, 0, 0};
    int          pos [3] = '{0, 0, 0};
    logic [7:0]  bq  [3][4];
    logic        done_e [3] = '{1'b0, 1'b0, 1'b0};

    int vecs = 0;
    int errs = 0;

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [31:0] d,
                              input logic rdy);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] m;
            logic [31:0] t;
            if (r) begin
                nb[i] = 0; pos[i] = 0; done_e[i] = 1'b0;
            end else if (pos[i] < nb[i]) begin
                done_e[i] = 1'b0;
                if (rdy) begin
                    pos[i]++;
                    if (pos[i] == nb[i]) begin
                        done_e[i] = 1'b1; nb[i] = 0; pos[i] = 0;
                    end
                end
            end else begin
                done_e[i] = 1'b0;
                if (s) begin
                    m = (wid[i] == 32) ? d : (d & ((32'd1 << wid[i]) - 32'd1));
                    nb[i]  = int'((wid[i] + 7) / 8);
                    pos[i] = 0;
                    for (int k = 0; k < 4; k++) begin
                        t = m >> (8 * k);
                        bq[i][k] = t[7:0];
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            logic       eb;
            logic [7:0] eo;
            logic [1:0] ei;
            eb = (pos[i] < nb[i]);
            eo = eb ? bq[i][pos[i]] : 8'h00;
            ei = eb ? 2'(pos[i]) : 2'd0;
            cmp($sformatf("%s/w%0d/busy", tag, wid[i]), {7'd0, busy_w[i]}, {7'd0, eb});
            cmp($sformatf("%s/w%0d/valid", tag, wid[i]), {7'd0, valid_w[i]}, {7'd0, eb});
            cmp($sformatf("%s/w%0d/byte", tag, wid[i]), bout_w[i], eo);
            cmp($sformatf("%s/w%0d/idx", tag, wid[i]), {6'd0, idx_w[i]}, {6'd0, ei});
            cmp($sformatf("%s/w%0d/done", tag, wid[i]), {7'd0, done_w[i]}, {7'd0, done_e[i]});
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [31:0] d,
                        input logic rdy, input string tag);
        rst = r; start = s; din = d; byte_ready = rdy;
        @(posedge clk);
        model_edge(r, s, d, rdy);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] tp1 [4];
        tp1[0] = 8'hD4; tp1[1] = 8'hC3; tp1[2] = 8'hB2; tp1[3] = 8'hA1;
        rst = 1'b1; start = 1'b0; din = '0; byte_ready = 1'b0;

        step(1'b1, 1'b0, 32'h0, 1'b0, "reset");
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, "reset_start");
        step(1'b0, 1'b0, 32'h0, 1'b0, "idle");

        // Full-speed transfer with explicit expected bytes.
        step(1'b0, 1'b1, 32'hA1B2_C3D4, 1'b1, "tp1_start");
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("tp1_byte%0d", k), bout_w[0], tp1[k]);
            cmp($sformatf("tp1_idx%0d", k), {6'd0, idx_w[0]}, 8'(k));
            step(1'b0, 1'b0, 32'h0, 1'b1, "tp1_run");
        end
        cmp("tp1_done", {7'd0, done_w[0]}, 8'd1);
        cmp("tp1_busy_low", {7'd0, busy_w[0]}, 8'd0);

        // Stall three cycles while byte 1 is presented.
        step(1'b0, 1'b1, 32'hA1B2_C3D4, 1'b1, "stall_start");
        step(1'b0, 1'b0, 32'h0, 1'b1, "stall_hs0");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, "stall_hold");
            cmp("stall_byte_c3", bout_w[0], 8'hC3);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1, "stall_drain");

        // Partial last byte and single-bit words.
        step(1'b0, 1'b1, 32'h0000_0ABC, 1'b1, "w12_start");
        cmp("w12_byte0", bout_w[1], 8'hBC);
        step(1'b0, 1'b0, 32'h0, 1'b1, "w12_run");
        cmp("w12_byte1", bout_w[1], 8'h0A);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b1, "w12_drain");
        step(1'b0, 1'b1, 32'h0000_0001, 1'b1, "w1_start");
        cmp("w1_byte", bout_w[2], 8'h01);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1, "w1_drain");

        // Start while busy is ignored; start in the done cycle is accepted.
        step(1'b0, 1'b1, 32'hA1B2_C3D4, 1'b1, "rep_start");
        step(1'b0, 1'b1, 32'h1111_1111, 1'b1, "rep_busy_start");
        step(1'b0, 1'b0, 32'h1111_1111, 1'b1, "rep_run");
        step(1'b0, 1'b0, 32'h1111_1111, 1'b1, "rep_run");
        step(1'b0, 1'b0, 32'h0, 1'b1, "rep_done");
        cmp("rep_done_w32", {7'd0, done_w[0]}, 8'd1);
        step(1'b0, 1'b1, 32'h5566_7788, 1'b1, "b2b_start");
        cmp("b2b_byte0", bout_w[0], 8'h88);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1, "b2b_run");

        // Reset in the middle of a transfer.
        step(1'b0, 1'b1, 32'hA1B2_C3D4, 1'b1, "rst_start");
        step(1'b0, 1'b0, 32'h0, 1'b1, "rst_c2");
        step(1'b1, 1'b0, 32'h0, 1'b1, "rst_mid");
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1, "rst_after");
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, "rst_restart");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b1, "rst_restart_run");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0), $urandom,
                 ($urandom_range(0, 3) != 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/byte_rd_serializer.md
Name: byte_rd_serializer

Overview:
- Read-back counterpart of the byte-enable register write path: captures a DATA_WIDTH-bit register value and streams it out one byte per handshake, LSB byte first.
- Emits a byte index matching the 2-bit byte-select convention, so a host can rebuild the word byte-by-byte.
- Sits between the controller's status/config registers and the byte-wide host read port.

Parameters:
- DATA_WIDTH, 32, width of captured word; legal range 1..32.
- NUM_BYTES, (DATA_WIDTH+7)/8, derived localparam, bytes per transfer (1..4).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a read-out of data_in; honoured only when not busy
- data_in  input  DATA_WIDTH  word to serialize, sampled on the accepted start edge
- busy  output  1  high from cycle after accepted start until the last byte handshake completes
- byte_out  output  8  current byte; upper bits zero-padded when DATA_WIDTH not a multiple of 8
- byte_valid  output  1  byte_out/byte_idx valid
- byte_ready  input  1  downstream accepts byte when high together with byte_valid
- byte_idx  output  2  index of byte currently on byte_out (0 = bits 7:0)
- done  output  1  one-cycle pulse after last byte accepted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state changes on rising clk.
- Reset values: busy=0, byte_valid=0, byte_out=0, byte_idx=0, done=0, shadow register=0, FSM=IDLE.
- FSM states: IDLE, SEND.
- IDLE: if start=1 then capture data_in into the shadow (zero-extended to 32 bits) and set byte_idx=0. Next cycle: SEND, busy=1, byte_valid=1, byte_out=shadow[7:0].
- SEND: handshake = byte_valid & byte_ready.
- SEND, no handshake: byte_out and byte_idx held stable (AXI-style; valid never drops without a handshake).
- SEND, handshake and byte_idx < NUM_BYTES-1: byte_idx increments; next byte presented the following cycle with no bubble.
- SEND, handshake on byte_idx = NUM_BYTES-1: next cycle IDLE, busy=0, byte_valid=0, done=1 for exactly that cycle.
- Throughput: NUM_BYTES+1 cycles from start to done with byte_ready tied high. Back-to-back transfers are allowed: start in the done cycle is accepted.
- start while busy is ignored; it is neither queued nor able to disturb the shadow.
- data_in changes after capture have no effect on the transfer in progress.
- DATA_WIDTH < 8: single byte, byte_out = {zeros, shadow[DATA_WIDTH-1:0]}.
- Partial last byte (e.g. width 12): upper bits of the last byte are 0.
- rst asserted mid-transfer: next cycle all outputs return to reset values. No done pulse. Remaining bytes are dropped.
- rst and start in the same cycle: rst wins and start is dropped.
- byte_ready sampled only while byte_valid=1; it is don't-care in IDLE.
- byte_idx is 0 in IDLE.

Test Plan:
- DATA_WIDTH=32, data_in=0xA1B2C3D4, start pulse, byte_ready=1 -> byte_out D4,C3,B2,A1 on cycles 1-4 with byte_idx 0-3; done=1 on cycle 5; busy=0 on cycle 5.
- Same word, byte_ready low for 3 cycles while byte_idx=1 -> byte_out stays 0xC3 and byte_valid stays 1 throughout the stall; transfer completes after the stall; done on cycle 8.
- DATA_WIDTH=1, data_in=1 -> one byte 0x01, byte_idx=0, done on cycle 2. DATA_WIDTH=12, data_in=0xABC -> bytes 0xBC, 0x0A.
- start re-pulsed at cycle 2 with data_in=0x11111111 during a 0xA1B2C3D4 transfer -> output unchanged, one done only. Then start in the done cycle with 0x55667788 -> 88,77,66,55 follow immediately.
- rst at cycle 2 of a transfer -> cycle 3: busy=0, byte_valid=0, byte_out=0; done never pulses; next start behaves as from reset.
